// File: rtl/pattern_sig_analyzer.sv
// Memory-scan signature analyzer: folds a block of 8-bit words into a MISR
// and tracks Hamming-distance statistics between consecutive words.
module pattern_sig_analyzer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic [8:0]  count,
    input  logic [7:0]  poly,
    input  logic [7:0]  seed,
    input  logic [7:0]  golden,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_rd,
    output logic        busy,
    output logic        done,
    output logic [7:0]  signature,
    output logic        pass,
    output logic [3:0]  hd_max,
    output logic [10:0] hd_sum
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state;
    logic [8:0]  remaining;
    logic [7:0]  poly_q;
    logic [7:0]  golden_q;
    logic [7:0]  prev;
    logic        first;

    logic [7:0]  sig_next;
    logic [7:0]  diff;
    logic [3:0]  hd;

    always_comb begin
        sig_next = {signature[6:0], 1'b0} ^ (signature[7] ? poly_q : 8'h00) ^ mem_rd;
        diff     = mem_rd ^ prev;
        hd       = 4'd0;
        for (int i = 0; i < 8; i++)
            hd = hd + {3'b000, diff[i]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= 9'd0;
            poly_q    <= 8'h00;
            golden_q  <= 8'h00;
            prev      <= 8'h00;
            first     <= 1'b0;
            mem_addr  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= 8'h00;
            pass      <= 1'b0;
            hd_max    <= 4'd0;
            hd_sum    <= 11'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        poly_q    <= poly;
                        golden_q  <= golden;
                        remaining <= count;
                        mem_addr  <= base_addr;
                        signature <= seed;
                        hd_max    <= 4'd0;
                        hd_sum    <= 11'd0;
                        prev      <= 8'h00;
                        first     <= 1'b1;
                        busy      <= 1'b1;
                        // An empty scan completes on the seed alone.
                        if (count == 9'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (seed == golden);
                        end else begin
                            state <= SCAN;
                            pass  <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    signature <= sig_next;
                    mem_addr  <= mem_addr + 8'd1;
                    remaining <= remaining - 9'd1;
                    prev      <= mem_rd;
                    first     <= 1'b0;
                    if (!first) begin
                        hd_sum <= hd_sum + {7'd0, hd};
                        if (hd > hd_max)
                            hd_max <= hd;
                    end
                    // pass must already be valid while done is high.
                    if (remaining == 9'd1) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (sig_next == golden_q);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pattern_sig_analyzer.md
PATTERN_SIG_ANALYZER -- requirements
Module: pattern_sig_analyzer

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 and address width at 8.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 base_addr  input  8  first data-memory address to scan.
REQ-006 count  input  9  number of words to scan, 0..256.
REQ-007 poly  input  8  MISR feedback taps.
REQ-008 seed  input  8  initial MISR value.
REQ-009 golden  input  8  expected final signature.
REQ-010 mem_addr  output  8  registered read address to the data memory.
REQ-011 mem_rd  input  8  memory read data; combinational and valid in the same cycle as mem_addr.
REQ-012 busy  output  1  high in SCAN and DONE.
REQ-013 done  output  1  one-cycle pulse when the result is valid.
REQ-014 signature  output  8  MISR register.
REQ-015 pass  output  1  signature == golden, registered at completion.
REQ-016 hd_max  output  4  largest Hamming distance between consecutive scanned words, 0..8.
REQ-017 hd_sum  output  11  sum of consecutive-word Hamming distances.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-019 In IDLE with start=1: latch count, poly and golden; set mem_addr=base_addr and signature=seed; clear hd_max, hd_sum and pass; go to SCAN if count!=0, else go to DONE.
REQ-020 Each SCAN cycle SHALL consume mem_rd: signature <= {signature[6:0],0} XOR (signature[7] ? poly : 0) XOR mem_rd.
REQ-021 Each SCAN cycle SHALL increment mem_addr modulo 256 (0xFF wraps to 0x00) and decrement the remaining count.
REQ-022 For every scanned word after the first, hd = popcount(mem_rd XOR previous word); hd_sum += hd; hd_max = max(hd_max, hd).
REQ-023 The first word of a scan SHALL contribute no Hamming distance; the previous-word register SHALL be cleared at start.
REQ-024 After the SCAN cycle that consumes the last word, the FSM SHALL go to DONE.
REQ-025 DONE SHALL last exactly one cycle with done=1 and pass=(signature==golden), then return to IDLE.
REQ-026 Latency: start sampled in cycle 0; SCAN occupies cycles 1..N; done is high in cycle N+1 (count=N). With count=0, done is high in cycle 1.
REQ-027 start SHALL be ignored while busy=1; it SHALL be accepted again in the cycle after DONE.
REQ-028 In IDLE, signature, pass, hd_max, hd_sum and mem_addr SHALL hold their values.
REQ-029 hd_sum SHALL not saturate; the maximum value is 255*8=2040, which fits in 11 bits.
REQ-030 Inputs other than mem_rd SHALL be ignored outside the start cycle; changes during a scan SHALL have no effect.

Reset
REQ-031 Asserting reset at any time, including mid-scan, SHALL force IDLE and return the following outputs to zero: mem_addr, busy, done, signature, pass, hd_max, hd_sum.
REQ-032 After reset deassertion, the first scan SHALL be accepted in the first cycle with start=1.

Verification
REQ-033 seed=0x00, poly=0x1D, count=1, mem[0x10]=0xA5, base=0x10 -> done in cycle 2, signature=0xA5, hd_max=0, hd_sum=0.
REQ-034 seed=0x00, poly=0x1D, count=2, base=0x10, mem[0x10]=0xA5, mem[0x11]=0x5A, golden=0x0D -> signature=0x0D, pass=1, hd_max=8, hd_sum=8.
REQ-035 Same as REQ-034 with golden=0x0C -> pass=0, done is a single-cycle pulse.
REQ-036 base=0xFE, count=4 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01; done in cycle 5.
REQ-037 count=0, seed=0x3C, golden=0x3C -> done in cycle 1, signature=0x3C, pass=1; a start pulse during a 10-word scan is ignored.
REQ-038 Reset asserted in cycle 3 of a 10-word scan -> all outputs listed in REQ-031 are 0 and the FSM is in IDLE; a subsequent scan completes correctly.
